dmem_arbiter: RTL and testbench

- Shares the single-ported data memory between the ARM core's load/store path and a debug/loader port.
- The debug port is used by benches and boot loaders to preload or inspect memory while the core runs.
- The CPU normally has priority. A starvation counter forces a debug grant after MAX_WAIT contended cycles and stalls the core for that one cycle.
- Sits between the datapath's memory-access signals and the data memory instance.

---
 rtl/dmem_arbiter_if.sv | 29 ++
 rtl/dmem_arbiter.sv | 48 ++++
 tb/tb_dmem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, debug and memory-side signals of the data-memory arbiter
// slave = arbiter view, master = the surrounding core/debugger/memory view
interface dmem_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic          cpu_we;
  logic          cpu_re;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_rvalid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input  cpu_we, cpu_re, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, dbg_gnt, dbg_rdata, dbg_rvalid, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_we, cpu_re, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, dbg_gnt, dbg_rdata, dbg_rvalid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU load/store path and a debug port
// ports: CLK, reset (sync, active-high), bus (cpu_*, dbg_*, mem_* via dmem_arbiter_if.slave)
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_WAIT = 4
) (
  input logic            CLK,
  input logic            reset,
  dmem_arbiter_if.slave  bus
);
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  logic          cpu_act;
  logic          dbg_own;
  logic [AW-1:0] mem_addr_c;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          dbg_rvalid_q, dbg_rvalid_d;
  always_comb begin
    cpu_act      = bus.cpu_we | bus.cpu_re;
    // debug wins when the CPU is idle or it has waited out the starvation limit
    dbg_own      = !reset && bus.dbg_req && (!cpu_act || wait_cnt_q == MW);
    mem_addr_c   = dbg_own ? bus.dbg_addr : bus.cpu_addr;
    wait_cnt_d   = (dbg_own || !bus.dbg_req) ? 4'd0 :
                   (cpu_act && wait_cnt_q != MW) ? wait_cnt_q + 4'd1 : wait_cnt_q;
    dbg_rvalid_d = dbg_own && !bus.dbg_we;
    dbg_rdata_d  = dbg_rvalid_d ? bus.mem_rdata : dbg_rdata_q;
  end
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = dbg_own ? bus.dbg_wdata : bus.cpu_wdata;
  assign bus.mem_we     = !reset && (dbg_own ? bus.dbg_we : bus.cpu_we);
  assign bus.dbg_gnt    = dbg_own;
  assign bus.cpu_stall  = dbg_own && cpu_act;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  always_ff @(posedge CLK) begin
    if (reset) begin
      wait_cnt_q   <= '0;
      dbg_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a 64-word memory model
module tb_dmem_arbiter;
  logic CLK = 1'b0;
  logic reset;
  logic init_mem;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] mem [64];
  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();
  dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (.CLK(CLK), .reset(reset), .bus(bus));
  always #5 CLK = ~CLK;
  assign bus.mem_rdata = mem[bus.mem_addr[5:0]];
  always @(posedge CLK) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000 + 32'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic next();
    @(posedge CLK);
    #1;
  endtask
  task automatic cpu(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_we = we; bus.cpu_re = re; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask
  task automatic dbg(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
  endtask
  initial begin
    reset = 1'b1;
    init_mem = 1'b1;
    cpu(1, 0, 10, 32'hdead);
    dbg(1, 1, 10, 32'hbeef);
    #2;
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_gnt", 32'(bus.dbg_gnt), 0);
    chk("rst_stall", 32'(bus.cpu_stall), 0);
    next();
    init_mem = 1'b0;
    #1;
    chk("rst2_mem_we", 32'(bus.mem_we), 0);
    chk("rst2_gnt", 32'(bus.dbg_gnt), 0);
    chk("rst2_rvalid", 32'(bus.dbg_rvalid), 0);
    chk("rst2_rdata", bus.dbg_rdata, 0);
    next();
    reset = 1'b0;
    cpu(0, 0, 0, 0);
    dbg(1, 1, 10, 32'h55);
    #1;
    chk("rst_mem10", mem[10], 32'h100a);
    chk("free_wr_gnt", 32'(bus.dbg_gnt), 1);
    chk("free_wr_stall", 32'(bus.cpu_stall), 0);
    chk("free_wr_mem_we", 32'(bus.mem_we), 1);
    chk("free_wr_addr", bus.mem_addr, 10);
    next();
    dbg(1, 0, 10, 0);
    #1;
    chk("free_rd_gnt", 32'(bus.dbg_gnt), 1);
    chk("free_rd_mem_we", 32'(bus.mem_we), 0);
    chk("free_wr_no_rvalid", 32'(bus.dbg_rvalid), 0);
    next();
    dbg(0, 0, 0, 0);
    #1;
    chk("free_rd_rvalid", 32'(bus.dbg_rvalid), 1);
    chk("free_rd_rdata", bus.dbg_rdata, 32'h55);
    next();
    #1;
    chk("free_rd_rvalid_pulse", 32'(bus.dbg_rvalid), 0);
    chk("free_rd_rdata_hold", bus.dbg_rdata, 32'h55);
    for (int c = 0; c <= 5; c++) begin
      next();
      cpu(0, 1, 32'(20 + c), 0);
      dbg(c <= 4, 0, 10, 0);
      #1;
      chk($sformatf("cont_gnt_c%0d", c), 32'(bus.dbg_gnt), 32'(c == 4));
      chk($sformatf("cont_stall_c%0d", c), 32'(bus.cpu_stall), 32'(c == 4));
      chk($sformatf("cont_rvalid_c%0d", c), 32'(bus.dbg_rvalid), 32'(c == 5));
      if (c != 4) chk($sformatf("cont_cpu_rdata_c%0d", c), bus.cpu_rdata, 32'h1000 + 32'(20 + c));
      if (c == 5) chk("cont_dbg_rdata", bus.dbg_rdata, 32'h55);
    end
    for (int c = 0; c <= 3; c++) begin
      next();
      cpu(0, 1, 30, 0);
      dbg(1, 1, 4, 9);
      #1;
      chk($sformatf("store_wait_gnt_c%0d", c), 32'(bus.dbg_gnt), 0);
    end
    next();
    cpu(1, 0, 3, 7);
    #1;
    chk("store_force_gnt", 32'(bus.dbg_gnt), 1);
    chk("store_force_stall", 32'(bus.cpu_stall), 1);
    chk("store_force_addr", bus.mem_addr, 4);
    chk("store_force_wdata", bus.mem_wdata, 9);
    chk("store_force_we", 32'(bus.mem_we), 1);
    next();
    dbg(0, 0, 0, 0);
    #1;
    chk("store_mem4", mem[4], 9);
    chk("store_mem3_untouched", mem[3], 32'h1003);
    chk("store_replay_stall", 32'(bus.cpu_stall), 0);
    chk("store_replay_addr", bus.mem_addr, 3);
    next();
    cpu(0, 0, 0, 0);
    #1;
    chk("store_mem3", mem[3], 7);
    for (int c = 0; c <= 10; c++) begin
      next();
      cpu(0, 1, 40, 0);
      dbg(c <= 9, 0, (c <= 4) ? 32'd10 : 32'd4, 0);
      #1;
      chk($sformatf("b2b_gnt_c%0d", c), 32'(bus.dbg_gnt), 32'(c == 4 || c == 9));
      chk($sformatf("b2b_stall_c%0d", c), 32'(bus.cpu_stall), 32'(c == 4 || c == 9));
      chk($sformatf("b2b_rvalid_c%0d", c), 32'(bus.dbg_rvalid), 32'(c == 5 || c == 10));
      if (c == 5) chk("b2b_rdata1", bus.dbg_rdata, 32'h55);
      if (c == 10) chk("b2b_rdata2", bus.dbg_rdata, 9);
    end
    for (int c = 0; c <= 8; c++) begin
      next();
      cpu(0, 1, 41, 0);
      dbg(c <= 7, 0, 3, 0);
      reset = (c == 2);
      #1;
      chk($sformatf("rmw_gnt_c%0d", c), 32'(bus.dbg_gnt), 32'(c == 7));
      chk($sformatf("rmw_stall_c%0d", c), 32'(bus.cpu_stall), 32'(c == 7));
      if (c == 8) chk("rmw_rvalid", 32'(bus.dbg_rvalid), 1);
      if (c == 8) chk("rmw_rdata", bus.dbg_rdata, 7);
    end
    for (int c = 0; c <= 5; c++) begin
      next();
      cpu(0, 1, 42, 0);
      dbg(c <= 4, c == 4, 5, 32'h77);
      reset = (c == 4);
      #1;
      if (c == 4) chk("rgnt_gnt", 32'(bus.dbg_gnt), 0);
      if (c == 4) chk("rgnt_mem_we", 32'(bus.mem_we), 0);
      if (c == 5) chk("rgnt_rvalid", 32'(bus.dbg_rvalid), 0);
      if (c == 5) chk("rgnt_mem5", mem[5], 32'h1005);
    end
    reset = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
